// File: rtl/btn_pkg.sv
// Shared types and width helpers for the push-button conditioner.
package btn_pkg;

    // Per-channel auto-repeat state.
    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RPT
    } rpt_state_t;

    // Debounce counter width; one spare bit above what the terminal count needs.
    function automatic int unsigned cnt_width(input int unsigned stable_count);
        return $clog2(stable_count) + 1;
    endfunction

    // Repeat counter width, sized for the longer of the two repeat intervals.
    function automatic int unsigned rcnt_width(input int unsigned repeat_delay,
                                               input int unsigned repeat_period);
        int unsigned longest;
        longest = (repeat_delay > repeat_period) ? repeat_delay : repeat_period;
        return $clog2(longest) + 1;
    endfunction

endpackage

// File: rtl/button_channel.sv
// One button channel: synchroniser, debounce counter, press/release pulses and auto-repeat.
module button_channel
    import btn_pkg::*;
#(
    parameter int unsigned SYNC_STAGES   = 2,
    parameter int unsigned STABLE_COUNT  = 2048,
    parameter int unsigned REPEAT_DELAY  = 500,
    parameter int unsigned REPEAT_PERIOD = 100
) (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic btn_raw,
    input  logic repeat_en,
    output logic level,
    output logic press,
    output logic release_pulse,
    output logic repeat_pulse,
    output logic act
);

    localparam int unsigned CntW  = cnt_width(STABLE_COUNT);
    localparam int unsigned RcntW = rcnt_width(REPEAT_DELAY, REPEAT_PERIOD);

    localparam logic [CntW-1:0]  CntLast    = CntW'(STABLE_COUNT - 1);
    localparam logic [RcntW-1:0] DelayLast  = RcntW'(REPEAT_DELAY - 1);
    localparam logic [RcntW-1:0] PeriodLast = RcntW'(REPEAT_PERIOD - 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   sync_bit;

    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             rose, fell;

    rpt_state_t       state_q, state_d;
    logic [RcntW-1:0] rcnt_q, rcnt_d;
    logic             rpt_d;

    logic press_q, release_q, repeat_q, act_q;

    // Raw input shifts in at bit 0; the top bit is the synchronised level.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], btn_raw};
    end

    assign sync_bit = sync_q[SYNC_STAGES-1];

    // Debounce: accept a new level only after STABLE_COUNT consecutive differing ticks.
    always_comb begin
        cnt_d   = cnt_q;
        level_d = level_q;
        if (sync_bit == level_q) begin
            // Any agreement, ticked or not, restarts the stability window.
            cnt_d = '0;
        end else if (tick) begin
            if (cnt_q == CntLast) begin
                level_d = sync_bit;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    assign rose = level_d & ~level_q;
    assign fell = ~level_d & level_q;

    // Auto-repeat: delay from press to first pulse, then a fixed period while held.
    always_comb begin
        state_d = state_q;
        rcnt_d  = rcnt_q;
        rpt_d   = 1'b0;
        if (!repeat_en || fell) begin
            // Release or disable both abort the sequence and win over a terminal count.
            state_d = IDLE;
            rcnt_d  = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    // Covers both a fresh press and enable rising while already held.
                    if (level_d) begin
                        state_d = WAIT;
                        rcnt_d  = '0;
                    end
                end
                WAIT: begin
                    if (tick) begin
                        if (rcnt_q == DelayLast) begin
                            rpt_d   = 1'b1;
                            rcnt_d  = '0;
                            state_d = RPT;
                        end else begin
                            rcnt_d = rcnt_q + 1'b1;
                        end
                    end
                end
                RPT: begin
                    if (tick) begin
                        if (rcnt_q == PeriodLast) begin
                            rpt_d  = 1'b1;
                            rcnt_d = '0;
                        end else begin
                            rcnt_d = rcnt_q + 1'b1;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                    rcnt_d  = '0;
                end
            endcase
        end
    end

    // All channel state and registered pulse outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q    <= '0;
            cnt_q     <= '0;
            level_q   <= 1'b0;
            state_q   <= IDLE;
            rcnt_q    <= '0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            repeat_q  <= 1'b0;
            act_q     <= 1'b0;
        end else begin
            sync_q    <= sync_d;
            cnt_q     <= cnt_d;
            level_q   <= level_d;
            state_q   <= state_d;
            rcnt_q    <= rcnt_d;
            press_q   <= rose;
            release_q <= fell;
            repeat_q  <= rpt_d;
            act_q     <= rose | rpt_d;
        end
    end

    assign level         = level_q;
    assign press         = press_q;
    assign release_pulse = release_q;
    assign repeat_pulse  = repeat_q;
    assign act           = act_q;

endmodule

// File: rtl/button_conditioner.sv
// N-channel push-button front end; channels are fully independent.
module button_conditioner
    import btn_pkg::*;
#(
    parameter int unsigned CHANNELS      = 4,
    parameter int unsigned SYNC_STAGES   = 2,
    parameter int unsigned STABLE_COUNT  = 2048,
    parameter int unsigned REPEAT_DELAY  = 500,
    parameter int unsigned REPEAT_PERIOD = 100
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                tick,
    input  logic [CHANNELS-1:0] btn_raw,
    input  logic [CHANNELS-1:0] repeat_en,
    output logic [CHANNELS-1:0] level,
    output logic [CHANNELS-1:0] press,
    // "release" is a reserved word, hence the suffix.
    output logic [CHANNELS-1:0] release_pulse,
    output logic [CHANNELS-1:0] repeat_pulse,
    output logic [CHANNELS-1:0] act,
    output logic                any_press
);

    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
        button_channel #(
            .SYNC_STAGES  (SYNC_STAGES),
            .STABLE_COUNT (STABLE_COUNT),
            .REPEAT_DELAY (REPEAT_DELAY),
            .REPEAT_PERIOD(REPEAT_PERIOD)
        ) u_chan (
            .clk          (clk),
            .rst          (rst),
            .tick         (tick),
            .btn_raw      (btn_raw[i]),
            .repeat_en    (repeat_en[i]),
            .level        (level[i]),
            .press        (press[i]),
            .release_pulse(release_pulse[i]),
            .repeat_pulse (repeat_pulse[i]),
            .act          (act[i])
        );
    end

    // Same-cycle OR of the registered press pulses.
    always_comb begin
        any_press = |press;
    end

endmodule
